// File: rtl/counter_bank_pkg.sv
// ============================================================================
// Module      : counter_bank_pkg
// Description : Opcodes and per-lane command encoding for counter_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_bank_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NOP             = 3'b000;
    localparam opcode_t OP_LOAD_CONST      = 3'b001;
    localparam opcode_t OP_DEC             = 3'b010;
    localparam opcode_t OP_LOAD_DATA       = 3'b011;
    localparam opcode_t OP_CLEAR_ALL       = 3'b100;
    localparam opcode_t OP_CLEAR           = 3'b101;
    localparam opcode_t OP_DEC_RELOAD_NEXT = 3'b110;
    localparam opcode_t OP_SHIFT_DATA      = 3'b111;

    typedef enum logic [2:0] {
        CMD_HOLD  = 3'd0,
        CMD_DEC   = 3'd1,
        CMD_LOAD  = 3'd2,
        CMD_CLEAR = 3'd3,
        CMD_SHIFT = 3'd4
    } lane_cmd_t;

endpackage

`default_nettype wire

// File: rtl/counter_lane.sv
// ============================================================================
// Module      : counter_lane
// Description : One saturating down-counter with sticky underflow flag.
//               COUNTER_BANK_AUTORELOAD_EN adds reload-on-zero and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_lane
    import counter_bank_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  lane_cmd_t             cmd,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [DATA_WIDTH-1:0] shift_byte,
`ifdef COUNTER_BANK_AUTORELOAD_EN
    input  logic                  autoreload,
    output logic                  wrap,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  underflow
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] w_shifted;

    // When WIDTH == DATA_WIDTH the shift clears the old value, giving a plain load.
    assign w_shifted = (count_q << DATA_WIDTH) | WIDTH'(shift_byte);

`ifdef COUNTER_BANK_AUTORELOAD_EN
    logic wrap_q, wrap_d;
`endif

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
`ifdef COUNTER_BANK_AUTORELOAD_EN
        wrap_d      = 1'b0;
`endif
        case (cmd)
            CMD_DEC: begin
                if (count_q == '0) begin
`ifdef COUNTER_BANK_AUTORELOAD_EN
                    if (autoreload) begin
                        count_d = load_value;
                        wrap_d  = 1'b1;
                    end else begin
                        underflow_d = 1'b1;
                    end
`else
                    underflow_d = 1'b1;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            CMD_LOAD: begin
                count_d     = load_value;
                underflow_d = 1'b0;
            end
            CMD_CLEAR: begin
                count_d     = '0;
                underflow_d = 1'b0;
            end
            CMD_SHIFT: count_d = w_shifted;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
`ifdef COUNTER_BANK_AUTORELOAD_EN
            wrap_q      <= 1'b0;
`endif
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
`ifdef COUNTER_BANK_AUTORELOAD_EN
            wrap_q      <= wrap_d;
`endif
        end
    end

    assign count     = count_q;
    assign underflow = underflow_q;
`ifdef COUNTER_BANK_AUTORELOAD_EN
    assign wrap      = wrap_q;
`endif

endmodule

`default_nettype wire

// File: rtl/counter_bank.sv
// ============================================================================
// Module      : counter_bank
// Description : Bank of down-counters driven by one opcode per cycle, plus a
//               background decrement on the last lane.
//               Optional macro: COUNTER_BANK_AUTORELOAD_EN (autoreload/wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int COUNTER_COUNT = 4,
    parameter int WIDTH         = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                             clock,
    input  logic                             rst_n,
    input  logic [2:0]                       op,
    input  logic [$clog2(COUNTER_COUNT)-1:0] sel,
    input  logic [COUNTER_COUNT*WIDTH-1:0]   const_data,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             bg_dec,
`ifdef COUNTER_BANK_AUTORELOAD_EN
    input  logic [COUNTER_COUNT-1:0]         autoreload,
    output logic [COUNTER_COUNT-1:0]         wrap,
`endif
    output logic [COUNTER_COUNT-1:0]         zero,
    output logic [COUNTER_COUNT-1:0]         underflow,
    output logic [WIDTH-1:0]                 sel_value
);

    localparam int SEL_W = $clog2(COUNTER_COUNT);
    localparam int LAST  = COUNTER_COUNT - 1;

    if (WIDTH < DATA_WIDTH) begin : g_width_check
        $error("counter_bank: WIDTH must be >= DATA_WIDTH");
    end
    if (COUNTER_COUNT < 2 || COUNTER_COUNT > 16) begin : g_count_check
        $error("counter_bank: COUNTER_COUNT must be in 2..16");
    end

    logic             w_sel_ok;
    logic [SEL_W-1:0] w_next_sel;
    logic [WIDTH-1:0] w_data_ext;
    lane_cmd_t        w_cmd   [COUNTER_COUNT];
    logic [WIDTH-1:0] w_load  [COUNTER_COUNT];
    logic [WIDTH-1:0] w_count [COUNTER_COUNT];

    assign w_sel_ok   = ({1'b0, sel} < (SEL_W+1)'(COUNTER_COUNT));
    assign w_next_sel = (sel == SEL_W'(LAST)) ? '0 : sel + SEL_W'(1);
    assign w_data_ext = WIDTH'(data_in);

    // The load value defaults to the lane constant so that DEC_RELOAD_NEXT and
    // autoreload both pick it up without extra muxing in the lane.
    always_comb begin
        for (int i = 0; i < COUNTER_COUNT; i++) begin
            w_cmd[i]  = CMD_HOLD;
            w_load[i] = const_data[i*WIDTH +: WIDTH];
            if (op == OP_CLEAR_ALL) begin
                w_cmd[i] = CMD_CLEAR;
            end else if (w_sel_ok && sel == SEL_W'(i)) begin
                case (op)
                    OP_LOAD_CONST:      w_cmd[i] = CMD_LOAD;
                    OP_DEC:             w_cmd[i] = CMD_DEC;
                    OP_LOAD_DATA: begin
                        w_cmd[i]  = CMD_LOAD;
                        w_load[i] = w_data_ext;
                    end
                    OP_CLEAR:           w_cmd[i] = CMD_CLEAR;
                    OP_DEC_RELOAD_NEXT: w_cmd[i] = CMD_DEC;
                    OP_SHIFT_DATA:      w_cmd[i] = CMD_SHIFT;
                    default: ;
                endcase
            end else if (w_sel_ok && op == OP_DEC_RELOAD_NEXT && w_next_sel == SEL_W'(i)) begin
                w_cmd[i] = CMD_LOAD;
            end
        end
        // Background decrement only fills an otherwise idle slot; it is never queued.
        if (bg_dec && w_cmd[LAST] == CMD_HOLD) begin
            w_cmd[LAST] = CMD_DEC;
        end
    end

    for (genvar gi = 0; gi < COUNTER_COUNT; gi++) begin : g_lane
        counter_lane #(
            .WIDTH      (WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clock      (clock),
            .rst_n      (rst_n),
            .cmd        (w_cmd[gi]),
            .load_value (w_load[gi]),
            .shift_byte (data_in),
`ifdef COUNTER_BANK_AUTORELOAD_EN
            .autoreload (autoreload[gi]),
            .wrap       (wrap[gi]),
`endif
            .count      (w_count[gi]),
            .underflow  (underflow[gi])
        );
    end

    always_comb begin
        zero      = '0;
        sel_value = '0;
        for (int i = 0; i < COUNTER_COUNT; i++) begin
            zero[i] = (w_count[i] == '0);
            if (sel == SEL_W'(i)) begin
                sel_value = w_count[i];
            end
        end
    end

endmodule

`default_nettype wire
